// File: rtl/uart_pkg.sv
// Shared types and constants for the serial receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_ARM   = 3'd3,
    S_CHECK = 3'd4
  } rx_state_e;

  localparam int FR_PAR           = 8;
  localparam int FR_STOP          = 9;
  localparam int CHK_W            = 12;
  localparam int DEF_CLKS_PER_BIT = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       parity_err;
    logic       framing_err;
  } rx_result_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-runs while not cleared, strobes at half- and full-bit terminal counts.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic half_tc,
  output logic full_tc
);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset || clear) cnt <= '0;
    else                 cnt <= cnt + CNT_W'(1);
  end

  assign half_tc = (cnt == HALF_TC);
  assign full_tc = (cnt == FULL_TC);

endmodule

// File: rtl/uart_rx_controller.sv
// Receive sequencer: samples the serial line, builds the check word, drives the
// external frame checker through set/check/reset and hands results to the consumer.
module uart_rx_controller import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_serial,
  output logic [CHK_W-1:0] chk_frame,
  output logic             chk_set,
  output logic             chk_reset,
  input  logic             chk_parity_error,
  input  logic             chk_framing_error,
  output logic [7:0]       rx_data,
  output logic             rx_parity_err,
  output logic             rx_framing_err,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             busy
);

  rx_state_e        state, next_state;
  logic [1:0]       sync;
  logic             rxs;
  logic             armed;
  logic [3:0]       bit_idx;
  logic [FR_STOP:0] frame;
  rx_result_t       res;
  logic             half_tc, full_tc, tmr_clear;

  assign rxs = sync[1];

  // Timer only runs while timing a bit; it restarts at each sample point.
  assign tmr_clear = !(state == S_START || state == S_SHIFT)
                   || (state == S_START && half_tc)
                   || (state == S_SHIFT && full_tc);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clear),
    .half_tc (half_tc),
    .full_tc (full_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (!rxs && armed) next_state = S_START;
      S_START: if (half_tc) next_state = rxs ? S_IDLE : S_SHIFT;
      S_SHIFT: if (full_tc && bit_idx == 4'd9) next_state = S_ARM;
      S_ARM:   next_state = S_CHECK;
      S_CHECK: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    chk_set   = (state == S_ARM);
    chk_reset = (state == S_CHECK);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync       <= 2'b11;
      armed      <= 1'b0;
      bit_idx    <= '0;
      frame      <= '0;
      chk_frame  <= '0;
      res        <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      sync  <= {sync[0], rx_serial};
      // A held-low line (break) must be seen high before another start can arm.
      armed <= (state == S_IDLE) && (armed || rxs);
      if (state == S_START) bit_idx <= '0;
      if (state == S_SHIFT && full_tc) begin
        frame <= {rxs, frame[FR_STOP:1]};
        if (bit_idx != 4'd9) bit_idx <= bit_idx + 4'd1;
      end
      if (state == S_ARM) chk_frame <= {2'b00, frame};
      if (state == S_CHECK) begin
        if (!rx_valid || rx_ready) begin
          res.data        <= frame[7:0];
          res.parity_err  <= chk_parity_error;
          res.framing_err <= chk_framing_error;
          rx_valid        <= 1'b1;
          rx_overrun      <= 1'b0;
        end else begin
          rx_overrun      <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

  assign rx_data        = res.data;
  assign rx_parity_err  = res.parity_err;
  assign rx_framing_err = res.framing_err;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench: frames pushed as sent, popped by monitors on handshake / checker cycle.
module tb_uart_rx_controller;

  localparam int CPB = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_serial = 1'b1;
  logic [11:0] chk_frame;
  logic        chk_set, chk_reset, chk_parity_error, chk_framing_error;
  logic [7:0]  rx_data;
  logic        rx_parity_err, rx_framing_err, rx_valid, rx_overrun, busy;
  logic        rx_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;   // 0 low, 1 high, 2 random
  int n_set = 0;
  logic [9:0]  exp_q[$];   // {framing_err, parity_err, data}
  logic [11:0] chk_q[$];
  logic        chk_busy;
  logic        prev_set = 1'b0;
  logic        after_res = 1'b0;

  uart_rx_controller #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .rx_serial         (rx_serial),
    .chk_frame         (chk_frame),
    .chk_set           (chk_set),
    .chk_reset         (chk_reset),
    .chk_parity_error  (chk_parity_error),
    .chk_framing_error (chk_framing_error),
    .rx_data           (rx_data),
    .rx_parity_err     (rx_parity_err),
    .rx_framing_err    (rx_framing_err),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .rx_overrun        (rx_overrun),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  // Behavioural frame checker: odd parity, stop must be 1; verdict while in CHECK.
  always @(posedge clock) begin
    if (!reset)         chk_busy <= 1'b0;
    else if (chk_set)   chk_busy <= 1'b1;
    else if (chk_reset) chk_busy <= 1'b0;
  end
  assign chk_parity_error  = chk_busy & (chk_frame[8] != ~^chk_frame[7:0]);
  assign chk_framing_error = chk_busy & ~chk_frame[9];

  always @(posedge clock) begin
    #2;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = ($urandom % 3 != 0);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    cyc(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit keep);
    if (keep) exp_q.push_back({~stop, par != ~^d, d});
    chk_q.push_back({2'b00, stop, par, d});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin cyc(1); n++; end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  // Monitors: consumer handshake and checker set/reset sequencing.
  always @(negedge clock) begin
    if (reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_spurious: got data %0h, expected no result", rx_data);
        end else begin
          check("rx_result", 32'({rx_framing_err, rx_parity_err, rx_data}), 32'(exp_q.pop_front()));
        end
      end
      if (chk_set && chk_reset) begin
        checks++; errors++;
        $display("FAIL chk_set_reset_overlap: got both high, expected exclusive");
      end
      if (after_res) check("valid_after_result", 32'(rx_valid), 1);
      if (chk_reset) begin
        check("chk_reset_follows_set", 32'(prev_set), 1);
        if (chk_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL chk_spurious: got frame %0h, expected no frame", chk_frame);
        end else begin
          check("chk_frame", 32'(chk_frame), 32'(chk_q.pop_front()));
        end
      end
      if (chk_set) n_set++;
      after_res = chk_reset;
      prev_set  = chk_set;
    end else begin
      after_res = 1'b0;
      prev_set  = 1'b0;
    end
  end

  initial begin
    int   s0;
    logic saw;
    logic [7:0] d;
    logic wrong, stop;

    // reset state
    cyc(3);
    check("reset_outputs", 32'({chk_frame, chk_set, chk_reset, rx_data, rx_parity_err,
                                rx_framing_err, rx_valid, rx_overrun, busy}), 0);
    reset = 1'b1;
    cyc(4);

    // 1: clean frame
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    cyc(20);
    drain();
    check("chk_frame_hold", 32'(chk_frame), 32'h3A5);

    // 2: wrong parity
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    cyc(20);
    drain();

    // 3: break after a zero stop bit, then a normal frame
    s0 = n_set;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    cyc(40 * CPB);
    rx_serial = 1'b1;
    cyc(2 * CPB);
    check("break_single_frame", 32'(n_set - s0), 1);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    cyc(20);
    drain();

    // 4: short low glitch
    s0 = n_set;
    saw = 1'b0;
    rx_serial = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(1); saw |= busy; end
    rx_serial = 1'b1;
    for (int i = 0; i < 10; i++) begin cyc(1); saw |= busy; end
    check("glitch_busy_seen", 32'(saw), 1);
    check("glitch_idle", 32'(busy), 0);
    check("glitch_no_set", 32'(n_set - s0), 0);
    cyc(CPB);

    // 5: overrun with consumer stalled
    ready_mode = 0;
    cyc(2);
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);   // ~^0x11 = 1, so parity 0 is wrong
    cyc(20);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    cyc(20);
    check("overrun_data", 32'(rx_data), 32'h11);
    check("overrun_valid", 32'(rx_valid), 1);
    check("overrun_flag", 32'(rx_overrun), 1);
    ready_mode = 1;
    cyc(1);
    ready_mode = 0;
    cyc(1);
    check("overrun_clr_valid", 32'(rx_valid), 0);
    check("overrun_clr_flag", 32'(rx_overrun), 0);
    check("overrun_queue", 32'(exp_q.size()), 0);
    ready_mode = 1;
    cyc(CPB);

    // 6: reset during data bit 3
    rx_serial = 1'b0; cyc(CPB);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    rx_serial = 1'b0; cyc(CPB / 2);
    reset = 1'b0;
    cyc(1);
    check("midframe_reset", 32'({chk_frame, chk_set, chk_reset, rx_data, rx_parity_err,
                                 rx_framing_err, rx_valid, rx_overrun, busy}), 0);
    reset = 1'b1;
    rx_serial = 1'b1;
    cyc(CPB);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    cyc(20);
    drain();

    // random frames, random consumer stalls
    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      d     = 8'($urandom);
      wrong = ($urandom % 4 == 0);
      stop  = ($urandom % 5 != 0);
      send_frame(d, wrong ? ~(~^d) : ~^d, stop, 1'b1);
      if (!stop) cyc($urandom_range(0, 3 * CPB));
      rx_serial = 1'b1;
      cyc($urandom_range(3, 40));
    end
    ready_mode = 1;
    cyc(20);
    drain();
    check("chk_queue_empty", 32'(chk_q.size()), 0);
    check("final_overrun", 32'(rx_overrun), 0);
    check("final_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
